// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - registered load/store unit with handshaked RAM port and bounded wait
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of clearing offset bits.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wvalid,
  input  logic [4:0]        in_waddr,
  input  logic [31:0]       in_wdata,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [2:0]        in_alusel,
  input  logic [6:0]        in_aluop,
  input  logic [31:0]       in_r2,
  output logic              ram_valid,
  input  logic              ram_ready,
  output logic              ram_write,
  output logic [3:0]        ram_byte,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i,
  input  logic              ram_ack,
  output logic              wb_valid,
  output logic              wvalid_o,
  output logic [4:0]        waddr_o,
  output logic [31:0]       wdata_o,
  output logic              bus_err,
  output logic              misalign_o
);
  localparam logic [2:0] SEL_LOAD  = 3'd1;
  localparam logic [2:0] SEL_STORE = 3'd2;
  localparam logic [6:0] OP_LB  = 7'd1, OP_LH  = 7'd2, OP_LW = 7'd3, OP_LBU = 7'd4,
                         OP_LHU = 7'd5, OP_SB  = 7'd6, OP_SH = 7'd7, OP_SW  = 7'd8;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;

  logic             ld_op, st_op, is_mem, trap;
  logic [1:0]       size, off;
  logic [3:0]       lanes;
  logic [31:0]      st_data;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       lat_op;
  logic [1:0]       lat_off;
  logic             lat_wvalid;
  logic [4:0]       lat_waddr;
  logic [31:0]      lat_wdata;
  logic [31:0]      shifted, ld_data;

  always_comb begin
    ld_op = 1'b0;
    st_op = 1'b0;
    size  = SZ_W;
    case (in_aluop)
      OP_LB, OP_LBU: begin ld_op = 1'b1; size = SZ_B; end
      OP_LH, OP_LHU: begin ld_op = 1'b1; size = SZ_H; end
      OP_LW:         begin ld_op = 1'b1; size = SZ_W; end
      OP_SB:         begin st_op = 1'b1; size = SZ_B; end
      OP_SH:         begin st_op = 1'b1; size = SZ_H; end
      OP_SW:         begin st_op = 1'b1; size = SZ_W; end
      default: ;
    endcase
    is_mem = (in_alusel == SEL_LOAD && ld_op) || (in_alusel == SEL_STORE && st_op);
    // Offset is forced to natural alignment; only reached for aligned accesses when trapping.
    case (size)
      SZ_B:    off = in_addr[1:0];
      SZ_H:    off = {in_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
    case (size)
      SZ_B:    lanes = 4'b0001 << off;
      SZ_H:    lanes = 4'b0011 << off;
      default: lanes = 4'b1111;
    endcase
    if (!st_op)
      st_data = 32'd0;
    else if (size == SZ_B)
      st_data = {4{in_r2[7:0]}};
    else if (size == SZ_H)
      st_data = {2{in_r2[15:0]}};
    else
      st_data = in_r2;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem && ((size == SZ_H && in_addr[0]) ||
                           (size == SZ_W && in_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    shifted = ram_data_i >> {lat_off, 3'b000};
    case (lat_op)
      OP_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
      OP_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
      OP_LBU:  ld_data = {24'd0, shifted[7:0]};
      OP_LHU:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      in_ready   <= 1'b1;
      ram_valid  <= 1'b0;
      ram_write  <= 1'b0;
      ram_byte   <= 4'd0;
      ram_addr   <= '0;
      ram_data_o <= 32'd0;
      wb_valid   <= 1'b0;
      wvalid_o   <= 1'b0;
      waddr_o    <= 5'd0;
      wdata_o    <= 32'd0;
      bus_err    <= 1'b0;
      misalign_o <= 1'b0;
      lat_op     <= 7'd0;
      lat_off    <= 2'd0;
      lat_wvalid <= 1'b0;
      lat_waddr  <= 5'd0;
      lat_wdata  <= 32'd0;
    end else begin
      wb_valid   <= 1'b0;
      bus_err    <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && trap) begin
            wb_valid   <= 1'b1;
            misalign_o <= 1'b1;
            wvalid_o   <= 1'b0;
            waddr_o    <= in_waddr;
            wdata_o    <= 32'd0;
          end else if (in_valid && is_mem) begin
            state      <= REQ;
            in_ready   <= 1'b0;
            ram_valid  <= 1'b1;
            ram_write  <= st_op;
            ram_byte   <= lanes;
            ram_addr   <= {in_addr[ADDR_W-1:2], 2'b00};
            ram_data_o <= st_data;
            lat_op     <= in_aluop;
            lat_off    <= off;
            lat_wvalid <= in_wvalid;
            lat_waddr  <= in_waddr;
            lat_wdata  <= in_wdata;
          end else if (in_valid) begin
            wb_valid <= 1'b1;
            wvalid_o <= in_wvalid;
            waddr_o  <= in_waddr;
            wdata_o  <= in_wdata;
          end
        end
        REQ: begin
          if (ram_ready) begin
            ram_valid <= 1'b0;
            cnt       <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // An ack arriving on the final wait cycle still completes the access.
          if (ram_ack) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            wb_valid <= 1'b1;
            wvalid_o <= lat_wvalid;
            waddr_o  <= lat_waddr;
            wdata_o  <= ram_write ? lat_wdata : ld_data;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            wb_valid <= 1'b1;
            bus_err  <= 1'b1;
            wvalid_o <= 1'b0;
            waddr_o  <= lat_waddr;
            wdata_o  <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
